// File: rtl/rain_lcd_pkg.sv
// Shared types, ASCII constants and helpers for the rain-level LCD text formatter.
package rain_lcd_pkg;

    localparam int unsigned LEVEL_W    = 10;
    localparam int unsigned BCD_W      = 16;
    localparam int unsigned LINE_W     = 128;
    localparam int unsigned WORD_W     = 64;
    localparam int unsigned CONV_STEPS = 10;

    // Displayed rain status; INIT only until the first sample is classified.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_DRY   = 2'd1,
        ST_LIGHT = 2'd2,
        ST_HEAVY = 2'd3
    } status_t;

    // Formatter control states.
    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_CONV   = 2'd1,
        FSM_FORMAT = 2'd2
    } fsm_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;

    localparam logic [95:0] LABEL_LEVEL  = "RAIN LEVEL: ";
    localparam logic [63:0] LABEL_STATUS = "STATUS: ";

    localparam logic [WORD_W-1:0] WORD_INIT  = "INIT    ";
    localparam logic [WORD_W-1:0] WORD_DRY   = "DRY     ";
    localparam logic [WORD_W-1:0] WORD_LIGHT = "LIGHT   ";
    localparam logic [WORD_W-1:0] WORD_HEAVY = "HEAVY   ";

    localparam logic [LINE_W-1:0] LINE1_RESET = {LABEL_LEVEL, {4{ASCII_DASH}}};
    localparam logic [LINE_W-1:0] LINE2_RESET = {LABEL_STATUS, WORD_INIT};

    // Fixed-width status word shown after "STATUS: ".
    function automatic logic [WORD_W-1:0] status_word(input status_t st);
        logic [WORD_W-1:0] w;
        w = WORD_INIT;
        case (st)
            ST_DRY:   w = WORD_DRY;
            ST_LIGHT: w = WORD_LIGHT;
            ST_HEAVY: w = WORD_HEAVY;
            default:  w = WORD_INIT;
        endcase
        return w;
    endfunction

    // One BCD digit as ASCII, or a space when blanked as a leading zero.
    function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
        return blank ? ASCII_SPACE : (ASCII_ZERO + {4'b0000, d});
    endfunction

    // Double-dabble correction: add 3 to every digit that is 5 or more.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = v;
        for (int i = 0; i < 4; i++) begin
            nib = v[4*i +: 4];
            if (nib >= 4'd5) begin
                r[4*i +: 4] = nib + 4'd3;
            end
        end
        return r;
    endfunction

    // Next status; hysteresis applies only to falling transitions.
    function automatic status_t classify(
        input status_t           prev,
        input logic [LEVEL_W-1:0] level,
        input int unsigned       thr_light,
        input int unsigned       thr_heavy,
        input int unsigned       hyst
    );
        int unsigned lvl;
        status_t     nxt;
        lvl = 32'(level);
        nxt = prev;
        if (lvl >= thr_heavy) begin
            nxt = ST_HEAVY;
        end else begin
            case (prev)
                ST_INIT: nxt = (lvl >= thr_light) ? ST_LIGHT : ST_DRY;
                ST_DRY:  nxt = (lvl >= thr_light) ? ST_LIGHT : ST_DRY;
                ST_LIGHT: begin
                    if (lvl < thr_light - hyst) nxt = ST_DRY;
                    else                         nxt = ST_LIGHT;
                end
                ST_HEAVY: begin
                    if (lvl < thr_light - hyst)      nxt = ST_DRY;
                    else if (lvl < thr_heavy - hyst) nxt = ST_LIGHT;
                    else                              nxt = ST_HEAVY;
                end
                default: nxt = ST_DRY;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rain_lcd_text_formatter_bin2bcd_seq.sv
// Sequential 10-bit binary to 4-digit BCD converter (shift-add-3, one bit per cycle).
module bin2bcd_seq
    import rain_lcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEVEL_W-1:0] bin,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    logic [LEVEL_W-1:0] shreg;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   step;
    logic [3:0]         cnt;
    logic               active;

    // One double-dabble iteration: correct digits, then shift in the next binary bit.
    always_comb begin
        step = '0;
        step = (bcd_adjust(acc) << 1) | BCD_W'(shreg[LEVEL_W-1]);
    end

    // Start performs the first shift directly; remaining shifts run while active.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
            bcd    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= BCD_W'(bin[LEVEL_W-1]);
                shreg  <= bin << 1;
                cnt    <= 4'd1;
                active <= 1'b1;
            end else if (active) begin
                acc   <= step;
                shreg <= shreg << 1;
                cnt   <= cnt + 4'd1;
                if (cnt == 4'(CONV_STEPS - 1)) begin
                    active <= 1'b0;
                    bcd    <= step;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rain_lcd_text_formatter.sv
// Converts each rain-level sample into two 16-character ASCII lines for the LCD print stage.
module rain_lcd_text_formatter
    import rain_lcd_pkg::*;
#(
    parameter int unsigned THR_LIGHT = 300,
    parameter int unsigned THR_HEAVY = 700,
    parameter int unsigned HYST      = 16
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         sample_valid,
    input  logic [9:0]   sample,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic         lines_valid,
    output logic         busy,
    output logic         overrun
);

    fsm_t               state;
    status_t            status;
    status_t            status_next;
    logic [LEVEL_W-1:0] level;
    logic               conv_start;
    logic               conv_done;
    logic [BCD_W-1:0]   bcd;
    logic [LINE_W-1:0]  line1_next;
    logic [LINE_W-1:0]  line2_next;

    bin2bcd_seq u_bin2bcd (
        .clk   (CLOCK_50),
        .reset (reset),
        .start (conv_start),
        .bin   (level),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // Text assembly: leading-zero blanking on the level, classified status word.
    always_comb begin
        logic [3:0] d3, d2, d1, d0;
        logic       blank3, blank2, blank1;
        d3 = bcd[15:12];
        d2 = bcd[11:8];
        d1 = bcd[7:4];
        d0 = bcd[3:0];
        blank3 = (d3 == 4'd0);
        blank2 = blank3 && (d2 == 4'd0);
        blank1 = blank2 && (d1 == 4'd0);
        line1_next  = {LABEL_LEVEL,
                       digit_char(d3, blank3),
                       digit_char(d2, blank2),
                       digit_char(d1, blank1),
                       digit_char(d0, 1'b0)};
        status_next = classify(status, level, THR_LIGHT, THR_HEAVY, HYST);
        line2_next  = {LABEL_STATUS, status_word(status_next)};
    end

    // Control FSM with registered outputs; busy trails the state by one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= FSM_IDLE;
            status      <= ST_INIT;
            level       <= '0;
            conv_start  <= 1'b0;
            line1       <= LINE1_RESET;
            line2       <= LINE2_RESET;
            lines_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            conv_start  <= 1'b0;
            lines_valid <= 1'b0;
            overrun     <= 1'b0;
            busy        <= (state != FSM_IDLE);
            case (state)
                FSM_IDLE: begin
                    if (sample_valid) begin
                        level      <= sample;
                        conv_start <= 1'b1;
                        state      <= FSM_CONV;
                    end
                end
                FSM_CONV: begin
                    if (sample_valid) overrun <= 1'b1;
                    if (conv_done)    state   <= FSM_FORMAT;
                end
                FSM_FORMAT: begin
                    if (sample_valid) overrun <= 1'b1;
                    line1       <= line1_next;
                    line2       <= line2_next;
                    status      <= status_next;
                    lines_valid <= 1'b1;
                    state       <= FSM_IDLE;
                end
                default: state <= FSM_IDLE;
            endcase
        end
    end

endmodule
